// File: rtl/wb_slave_timer.sv
// Wishbone slave with a prescaled 32-bit match timer; ack one cycle after the hit cycle.
// One ack per strobe; the master holds stb, and the slave waits in HOLD until stb/cyc drop.
module wb_slave_timer #(
  parameter int                  ADDR_WID  = 32,
  parameter int                  DATA_WID  = 32,
  parameter logic [ADDR_WID-1:0] BASE_ADDR = '0
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic [ADDR_WID-1:0] s_wb_addr_i,
  input  logic [DATA_WID-1:0] s_wb_data_i,
  output logic [DATA_WID-1:0] s_wb_data_o,
  input  logic                s_wb_we_i,
  input  logic                s_wb_cyc_i,
  input  logic                s_wb_stb_i,
  output logic                s_wb_ack_o,
  output logic                irq_o
);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
  localparam logic [31:0] ID_VAL = 32'h5742_0001;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] data_q, data_d;
  logic        irq_q, irq_d;

  logic [31:0] scratch_q, scratch_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        match_q, match_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] presc_q, presc_d;

  logic        hit, acc, wr, rd;
  logic [2:0]  idx;
  logic [7:0]  wr_sel;
  logic [31:0] rdata;
  logic [31:0] wdat;
  logic        tick, count_eq;
  logic        unused_addr_bits;

  assign hit  = s_wb_cyc_i & s_wb_stb_i &
                (s_wb_addr_i[ADDR_WID-1:5] == BASE_ADDR[ADDR_WID-1:5]);
  assign idx  = s_wb_addr_i[4:2];
  assign acc  = (state_q == IDLE) & hit;
  assign wr   = acc & s_wb_we_i;
  assign rd   = acc & ~s_wb_we_i;
  assign wdat = s_wb_data_i;
  assign wr_sel = wr ? (8'b1 << idx) : 8'b0;
  assign unused_addr_bits = ^s_wb_addr_i[1:0];

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata = ID_VAL;
      3'd1:    rdata = scratch_q;
      3'd2:    rdata = {29'b0, ctrl_q};
      3'd3:    rdata = {31'b0, match_q};
      3'd4:    rdata = count_q;
      3'd5:    rdata = compare_q;
      3'd6:    rdata = {16'b0, prescale_q};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = HOLD;
      HOLD:    if (!s_wb_stb_i || !s_wb_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is captured at the hit edge so it reflects pre-write/pre-tick state.
  always_comb begin
    ack_d  = (state_d == ACK);
    data_d = rd ? rdata : '0;
  end

  assign tick     = ctrl_q[0] & (presc_q == prescale_q);
  assign count_eq = (count_q == compare_q);

  always_comb begin
    scratch_d  = wr_sel[1] ? wdat : scratch_q;
    ctrl_d     = wr_sel[2] ? wdat[2:0] : ctrl_q;
    compare_d  = wr_sel[5] ? wdat : compare_q;
    prescale_d = wr_sel[6] ? wdat[15:0] : prescale_q;

    presc_d = presc_q;
    if (wr_sel[6])      presc_d = '0;
    else if (ctrl_q[0]) presc_d = tick ? 16'd0 : presc_q + 16'd1;

    count_d = count_q;
    if (tick) count_d = (count_eq && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    if (wr_sel[4]) count_d = wdat;

    // A set from the timer beats a same-cycle W1C.
    match_d = match_q;
    if (wr_sel[3] && wdat[0]) match_d = 1'b0;
    if (tick && count_eq)     match_d = 1'b1;

    irq_d = match_q & ctrl_q[2];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ack_q      <= 1'b0;
      data_q     <= '0;
      irq_q      <= 1'b0;
      scratch_q  <= '0;
      ctrl_q     <= '0;
      match_q    <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      prescale_q <= '0;
      presc_q    <= '0;
    end else begin
      ack_q      <= ack_d;
      data_q     <= data_d;
      irq_q      <= irq_d;
      scratch_q  <= scratch_d;
      ctrl_q     <= ctrl_d;
      match_q    <= match_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      presc_q    <= presc_d;
    end
  end

  assign s_wb_ack_o  = ack_q;
  assign s_wb_data_o = data_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_slave_timer.sv
// Directed bench for wb_slave_timer: bus handshake, register map, timer and reset.
module tb_wb_slave_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_ID = BASE + 32'h00, A_SCR = BASE + 32'h04, A_CTRL = BASE + 32'h08,
                          A_STAT = BASE + 32'h0C, A_CNT = BASE + 32'h10, A_CMP = BASE + 32'h14,
                          A_PRE = BASE + 32'h18, A_RSV = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_o;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic        ack, irq;

  int n_checks = 0;
  int n_errors = 0;

  wb_slave_timer #(.ADDR_WID(32), .DATA_WID(32), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .s_wb_addr_i(addr), .s_wb_data_i(wdata), .s_wb_data_o(rdata_o),
    .s_wb_we_i(we), .s_wb_cyc_i(cyc), .s_wb_stb_i(stb),
    .s_wb_ack_o(ack), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; hit lands on the next posedge; returns two negedges after the ack.
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] r);
    logic got;
    got = 1'b0;
    r   = '0;
    addr = a; we = w; wdata = d; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        r   = rdata_o;
      end
    end
    check("ack_seen", {31'b0, got}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(a, 1'b1, d, r);
  endtask

  task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(a, 1'b0, 32'h0, r);
    check(tag, r, exp);
  endtask

  task automatic miss_access(input string tag, input logic [31:0] a, input logic w);
    int acks;
    acks = 0;
    addr = a; we = w; wdata = 32'h1234_5678; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check(tag, acks, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acks;
    #2 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", rdata_o, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    wb_read("rst_id",   A_ID,   32'h5742_0001);
    wb_read("rst_scr",  A_SCR,  32'd0);
    wb_read("rst_ctrl", A_CTRL, 32'd0);
    wb_read("rst_cnt",  A_CNT,  32'd0);

    // ID read with stb held three cycles: single ack, one cycle after the hit cycle
    addr = A_ID; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    #1 check("id_no_ack_in_hit", {31'b0, ack}, 32'd0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack) acks++;
      if (i == 0) begin
        check("id_ack_lat", {31'b0, ack}, 32'd1);
        check("id_data", rdata_o, 32'h5742_0001);
      end else begin
        check("id_data_zero", rdata_o, 32'd0);
      end
    end
    check("id_ack_count", acks, 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Register map behaviour and address decode
    wb_write(A_SCR, 32'hDEAD_BEEF);
    wb_read("scr_rb", A_SCR, 32'hDEAD_BEEF);
    miss_access("miss_rd_ack", BASE + 32'h40, 1'b0);
    miss_access("miss_wr_ack", BASE + 32'h44, 1'b1);
    wb_read("scr_after_miss", A_SCR, 32'hDEAD_BEEF);
    wb_write(A_ID, 32'hFFFF_FFFF);
    wb_read("id_ro", A_ID, 32'h5742_0001);
    wb_write(A_RSV, 32'hFFFF_FFFF);
    wb_read("rsv_zero", A_RSV, 32'd0);
    wb_write(A_PRE, 32'hFFFF_FFFF);
    wb_read("pre_mask", A_PRE, 32'h0000_FFFF);

    // Prescaled match with autoreload; CTRL hit edge is E, task returns after E+2
    wb_write(A_PRE, 32'd3);
    wb_write(A_CMP, 32'd2);
    wb_write(A_CTRL, 32'h7);
    repeat (9) @(negedge clk);
    check("irq_pre_match", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_latency", {31'b0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'd1);
    wb_read("cnt_reload", A_CNT, 32'd0);
    wb_read("stat_match", A_STAT, 32'd1);
    wb_write(A_STAT, 32'd1);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    wb_read("stat_cleared", A_STAT, 32'd0);
    wb_write(A_CTRL, 32'd0);
    wb_write(A_STAT, 32'd1);
    wb_read("stat_idle", A_STAT, 32'd0);

    // Wrap: 0xFFFFFFFF plus three ticks (enable at E, disable at E+3)
    wb_write(A_CNT, 32'hFFFF_FFFF);
    wb_write(A_CMP, 32'd5);
    wb_write(A_PRE, 32'd0);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_CTRL, 32'h0);
    wb_read("cnt_wrap", A_CNT, 32'd2);
    wb_read("wrap_no_match", A_STAT, 32'd0);

    // Bus write to COUNT coincides with a tick (every cycle ticks at PRESCALE=0)
    wb_write(A_CTRL, 32'h1);
    wb_write(A_CNT, 32'h100);
    wb_write(A_CTRL, 32'h0);
    wb_read("cnt_override", A_CNT, 32'h103);

    // W1C coincides with the match edge (COUNT 0->1->2, match at E+3)
    wb_write(A_CNT, 32'd0);
    wb_write(A_CMP, 32'd2);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_STAT, 32'd1);
    wb_write(A_CTRL, 32'h0);
    wb_read("match_beats_w1c", A_STAT, 32'd1);
    wb_read("cnt_no_reload", A_CNT, 32'd6);
    check("irq_masked", {31'b0, irq}, 32'd0);

    // Reset pulse during ACK, stb held through and after the reset
    addr = A_SCR; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("pre_rst_ack", {31'b0, ack}, 32'd1);
    check("pre_rst_dat", rdata_o, 32'hDEAD_BEEF);
    #2 nrst = 1'b0;
    #1 check("async_ack", {31'b0, ack}, 32'd0);
    check("async_dat", rdata_o, 32'd0);
    @(negedge clk);
    check("held_ack", {31'b0, ack}, 32'd0);
    #1 nrst = 1'b1;
    @(negedge clk);
    check("reack", {31'b0, ack}, 32'd1);
    check("reack_dat", rdata_o, 32'd0);
    @(negedge clk);
    check("reack_once", {31'b0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wb_read("post_id",   A_ID,   32'h5742_0001);
    wb_read("post_scr",  A_SCR,  32'd0);
    wb_read("post_ctrl", A_CTRL, 32'd0);
    wb_read("post_stat", A_STAT, 32'd0);
    wb_read("post_cnt",  A_CNT,  32'd0);
    wb_read("post_cmp",  A_CMP,  32'd0);
    wb_read("post_pre",  A_PRE,  32'd0);
    check("post_irq", {31'b0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_slave_timer.md
WB_SLAVE_TIMER -- requirements
Module: wb_slave_timer

Interface
REQ-001 SHALL have parameter ADDR_WID, default 32, meaning Wishbone address width.
REQ-002 SHALL have parameter DATA_WID, default 32, meaning Wishbone data width; only 32 is supported.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning byte base of the 32-byte register window.
REQ-004 SHALL have port clk_i  input  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port nrst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_wb_addr_i  input  ADDR_WID  byte address.
REQ-007 SHALL have port s_wb_data_i  input  DATA_WID  write data.
REQ-008 SHALL have port s_wb_data_o  output  DATA_WID  read data.
REQ-009 SHALL have port s_wb_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port s_wb_cyc_i  input  1  bus cycle active.
REQ-011 SHALL have port s_wb_stb_i  input  1  strobe.
REQ-012 SHALL have port s_wb_ack_o  output  1  transfer acknowledge, registered.
REQ-013 SHALL have port irq_o  output  1  timer interrupt, registered, level.

Function
REQ-014 SHALL treat an access as a hit when cyc and stb are both 1 and addr[ADDR_WID-1:5] equals BASE_ADDR[ADDR_WID-1:5]; register index = addr[4:2]; addr[1:0] ignored.
REQ-015 SHALL never assert ack for a miss, and SHALL leave all registers unchanged on a miss.
REQ-016 SHALL use a handshake FSM with states IDLE, ACK and HOLD.
- IDLE -> ACK on hit; a write commits at that clock edge.
- ACK: ack_o = 1 for exactly one cycle; data_o holds the read value captured at the hit edge; -> HOLD.
- HOLD: ack_o = 0; -> IDLE when stb = 0 or cyc = 0; otherwise remain in HOLD.
REQ-017 SHALL give a read-to-ack latency of 1 cycle after the hit cycle, and SHALL produce no second ack while stb stays high.
REQ-018 SHALL drive data_o = 0 in every cycle except the ACK cycle of a read.
REQ-019 SHALL implement this register map:
- 0 ID: RO, 0x57420001.
- 1 SCRATCH: RW, 32 bits.
- 2 CTRL: RW; bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
- 3 STATUS: bit0 MATCH, write-1-to-clear; other bits read 0.
- 4 COUNT: RW, 32 bits.
- 5 COMPARE: RW, 32 bits.
- 6 PRESCALE: RW, bits[15:0]; upper bits read 0.
- 7 reserved: reads 0, writes ignored.
REQ-020 SHALL, while EN = 1, run a 16-bit prescaler counting 0..PRESCALE; the cycle in which the prescaler equals PRESCALE is a tick, and the prescaler then returns to 0. PRESCALE = 0 SHALL give a tick every cycle.
REQ-021 SHALL, on a tick, act on COUNT as follows:
- COUNT == COMPARE: set MATCH; next COUNT = 0 if AUTORELOAD, else COUNT+1.
- Otherwise: COUNT+1, modulo 2^32, with 0xFFFFFFFF wrapping to 0.
REQ-022 SHALL hold the prescaler and COUNT with no ticks while EN = 0; the prescaler value is retained.
REQ-023 SHALL clear the prescaler to 0 when PRESCALE is written.
REQ-024 SHALL let a bus write to COUNT override the tick update in the same cycle.
REQ-025 SHALL let a MATCH set win over a same-cycle W1C clear.
REQ-026 SHALL register irq_o <= MATCH & IRQEN, so irq_o follows with 1-cycle latency.

Reset
REQ-027 SHALL, while nrst_i = 0, asynchronously force the following, regardless of any bus cycle in progress:
- ack_o = 0, data_o = 0, irq_o = 0.
- FSM = IDLE.
- SCRATCH, CTRL, STATUS, COUNT, COMPARE, PRESCALE and the prescaler = 0.
REQ-028 SHALL, after reset deassertion mid-cycle with stb still high, treat the access as a new hit and ack it once.

Verification
REQ-029 SHALL be covered by these directed scenarios:
- Read ID at BASE_ADDR+0x00 -> ack one cycle after the hit cycle; data_o = 0x57420001; exactly one ack while stb is held 3 cycles.
- Write SCRATCH 0xDEADBEEF, then read it -> read returns 0xDEADBEEF; access at BASE_ADDR+0x40 -> no ack for 10 cycles and SCRATCH unchanged.
- PRESCALE = 3, COMPARE = 2, CTRL = 0x7 -> MATCH set and irq_o = 1 after 12 ticks-worth of cycles (COUNT ticks 0,1,2); COUNT then reloads to 0; W1C of STATUS = 1 -> irq_o = 0 on the next cycle.
- COUNT = 0xFFFFFFFF, COMPARE = 5, PRESCALE = 0, CTRL = 0x1 -> COUNT = 0 after one tick; MATCH remains 0.
- Bus write COUNT = 0x100 in the same cycle as a tick -> COUNT = 0x100; W1C in the same cycle as a match -> MATCH stays 1.
- nrst_i pulsed low during the ACK state -> ack_o = 0 immediately, and all registers read 0 (ID reads 0x57420001).
